// File: rtl/xor_cipher_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xor_cipher_pkg
//  Description : Shared types and sizing helpers for the streaming XOR cipher.
//                Holds the controller state encoding plus constant functions
//                that derive beat counts and counter widths from parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package xor_cipher_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_KEY = 2'd1,
        READY    = 2'd2,
        STREAM   = 2'd3
    } state_t;

    // Number of DATA_W-wide beats needed to carry 'size' bits.
    function automatic int beats(input int size, input int lane_w);
        return size / lane_w;
    endfunction

    // Counter width able to hold the value n itself (one extra bit of headroom).
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage : xor_cipher_pkg
`default_nettype wire

// File: rtl/xor_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : xor_key_schedule
//  Description : Key storage for the streaming XOR cipher. Shifts key lanes
//                in MSB-first, optionally rotates the working key after each
//                full key pass and restores it from a shadow copy at the end
//                of a message. Presents the key lane selected by lane_idx.
//  Ports       : clk/rst      - clock, synchronous active-high reset
//                load         - shift data_in into the key (one lane)
//                clear        - start a fresh key with this load beat
//                rotate       - rotate working key left by one bit
//                restore      - reload working key from the shadow copy
//                lane_idx     - lane to present on key_lane
//                data_in      - incoming key lane
//                key_lane     - currently selected key lane
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_key_schedule #(
    parameter int DATA_W     = 1,
    parameter int KEY_SIZE   = 32,
    parameter int KEY_EVOLVE = 0,
    parameter int LANE_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              rotate,
    input  logic              restore,
    input  logic [LANE_W-1:0] lane_idx,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] key_lane
);

    logic [KEY_SIZE-1:0] r_key;
    logic [KEY_SIZE-1:0] w_base;
    logic [KEY_SIZE-1:0] w_shifted;
    logic [KEY_SIZE-1:0] w_lane_sh;

    // A clearing load starts the key from zero so only this beat survives.
    assign w_base    = clear ? '0 : r_key;
    assign w_shifted = (w_base << DATA_W) | KEY_SIZE'(data_in);

    // Lane 0 is the most significant lane (the first one loaded).
    assign w_lane_sh = r_key << (lane_idx * DATA_W);
    assign key_lane  = w_lane_sh[KEY_SIZE-1 -: DATA_W];

    generate
        if (KEY_EVOLVE != 0) begin : g_evolve
            logic [KEY_SIZE-1:0] r_shadow;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_key    <= '0;
                    r_shadow <= '0;
                end else if (load) begin
                    r_key    <= w_shifted;
                    r_shadow <= w_shifted;
                end else if (restore) begin
                    r_key    <= r_shadow;
                end else if (rotate) begin
                    r_key    <= (r_key << 1) | (r_key >> (KEY_SIZE - 1));
                end
            end
        end else begin : g_static
            logic w_unused_evolve_ctl;
            assign w_unused_evolve_ctl = rotate ^ restore;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_key <= '0;
                end else if (load) begin
                    r_key <= w_shifted;
                end
            end
        end
    endgenerate

endmodule : xor_key_schedule
`default_nettype wire

// File: rtl/xor_stream_cipher.sv
`default_nettype none
// ============================================================================
//  Module      : xor_stream_cipher
//  Description : Parametrised streaming XOR cipher. Loads a KEY_SIZE key one
//                DATA_W lane per beat, then XORs a MSG_SIZE message lane by
//                lane against the cyclically reused key. Output is registered
//                (one cycle latency) with start/end framing.
//  Ports       : iClk/iRst    - clock, synchronous active-high reset
//                iEn          - global enable, freezes all state when low
//                iData_in     - shared key/message input lane
//                iLoad_key    - key beat strobe
//                iLoad_msg    - message beat strobe
//                oData_out    - ciphertext lane
//                oValid       - oData_out valid
//                oStart/oEnd  - first/last ciphertext beat of a message
//                oKey_ready   - complete key held
//                oBusy        - message in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_stream_cipher
    import xor_cipher_pkg::*;
#(
    parameter int DATA_W     = 1,
    parameter int KEY_SIZE   = 32,
    parameter int MSG_SIZE   = 512,
    parameter int KEY_EVOLVE = 0
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEn,
    input  logic [DATA_W-1:0] iData_in,
    input  logic              iLoad_key,
    input  logic              iLoad_msg,
    output logic [DATA_W-1:0] oData_out,
    output logic              oValid,
    output logic              oStart,
    output logic              oEnd,
    output logic              oKey_ready,
    output logic              oBusy
);

    localparam int c_key_beats = beats(KEY_SIZE, DATA_W);
    localparam int c_msg_beats = beats(MSG_SIZE, DATA_W);
    localparam int c_kcnt_w    = cnt_w(c_key_beats);
    localparam int c_mcnt_w    = cnt_w(c_msg_beats);
    localparam int c_lane_w    = cnt_w(c_key_beats);

    state_t                r_state;
    state_t                w_state_next;
    logic [c_kcnt_w-1:0]   r_key_cnt;
    logic [c_mcnt_w-1:0]   r_msg_cnt;
    logic [c_lane_w-1:0]   r_lane_idx;

    logic                  w_key_beat;
    logic                  w_key_last;
    logic                  w_key_clear;
    logic                  w_msg_beat;
    logic                  w_msg_last;
    logic                  w_lane_wrap;
    logic [DATA_W-1:0]     w_key_lane;

    logic                  w_valid_d;
    logic                  w_start_d;
    logic                  w_end_d;
    logic                  w_key_ready_d;
    logic                  w_busy_d;

    logic [DATA_W-1:0]     r_data_out;
    logic                  r_valid;
    logic                  r_start;
    logic                  r_end;
    logic                  r_key_ready;
    logic                  r_busy;

    // Key beats are refused while a message is in flight. In READY a key beat
    // takes priority over a simultaneous message beat, which is then dropped.
    assign w_key_beat  = iEn & iLoad_key & (r_state != STREAM);
    assign w_key_last  = w_key_beat & (r_key_cnt == c_kcnt_w'(c_key_beats - 1));
    assign w_key_clear = w_key_beat & (r_state == READY);
    assign w_msg_beat  = iEn & iLoad_msg &
                         ((r_state == STREAM) | ((r_state == READY) & ~iLoad_key));
    assign w_msg_last  = w_msg_beat & (r_msg_cnt == c_mcnt_w'(c_msg_beats - 1));
    assign w_lane_wrap = w_msg_beat & (r_lane_idx == c_lane_w'(c_key_beats - 1));

    xor_key_schedule #(
        .DATA_W     (DATA_W),
        .KEY_SIZE   (KEY_SIZE),
        .KEY_EVOLVE (KEY_EVOLVE),
        .LANE_W     (c_lane_w)
    ) u_key_schedule (
        .clk      (iClk),
        .rst      (iRst),
        .load     (w_key_beat),
        .clear    (w_key_clear),
        .rotate   (w_lane_wrap & ~w_msg_last),
        .restore  (w_msg_last),
        .lane_idx (r_lane_idx),
        .data_in  (iData_in),
        .key_lane (w_key_lane)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic (strobes already carry iEn, so a low iEn holds state)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, LOAD_KEY: begin
                if (w_key_beat) begin
                    w_state_next = w_key_last ? READY : LOAD_KEY;
                end
            end
            READY: begin
                if (w_key_beat) begin
                    w_state_next = w_key_last ? READY : LOAD_KEY;
                end else if (w_msg_beat) begin
                    w_state_next = w_msg_last ? READY : STREAM;
                end
            end
            STREAM: begin
                if (w_msg_last) begin
                    w_state_next = READY;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (values captured by the output registers)
    // ------------------------------------------------------------------
    always_comb begin
        w_valid_d     = w_msg_beat;
        w_start_d     = w_msg_beat & (r_msg_cnt == '0);
        w_end_d       = w_msg_last;
        w_key_ready_d = (w_state_next == READY) | (w_state_next == STREAM);
        w_busy_d      = (w_state_next == STREAM);
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_key_cnt  <= '0;
            r_msg_cnt  <= '0;
            r_lane_idx <= '0;
        end else begin
            if (w_key_beat) begin
                r_key_cnt <= w_key_last ? '0 : r_key_cnt + c_kcnt_w'(1);
            end
            if (w_msg_beat) begin
                r_msg_cnt  <= w_msg_last ? '0 : r_msg_cnt + c_mcnt_w'(1);
                r_lane_idx <= (w_msg_last | w_lane_wrap) ? '0
                                                         : r_lane_idx + c_lane_w'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers; strobes drop to zero whenever no beat is accepted
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_key_ready <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid <= w_valid_d;
            r_start <= w_start_d;
            r_end   <= w_end_d;
            if (w_msg_beat) begin
                r_data_out <= iData_in ^ w_key_lane;
            end
            if (iEn) begin
                r_key_ready <= w_key_ready_d;
                r_busy      <= w_busy_d;
            end
        end
    end

    assign oData_out  = r_data_out;
    assign oValid     = r_valid;
    assign oStart     = r_start;
    assign oEnd       = r_end;
    assign oKey_ready = r_key_ready;
    assign oBusy      = r_busy;

endmodule : xor_stream_cipher
`default_nettype wire

// File: doc/xor_stream_cipher.md
Name: xor_stream_cipher

Overview:
Parametrised streaming XOR cipher engine. It is the successor to the fixed 32-bit-key / 512-bit-message buffered datapath.
- Loads a KEY_SIZE key DATA_W bits per beat, then encrypts a MSG_SIZE message on the fly, one DATA_W lane per beat.
- No full-message buffering; the key is reused cyclically, with an optional per-pass key evolution.
- Sits between the pin-level input demux and the output pins of the tile top.

Parameters:
DATA_W, 1, lane width in bits per beat (1 reproduces bit-serial operation)
KEY_SIZE, 32, key length in bits; must be a multiple of DATA_W
MSG_SIZE, 512, message length in bits; must be a multiple of DATA_W
KEY_EVOLVE, 0, 1 = rotate key left by 1 bit after every complete key pass

Ports:
iClk  input  1  clock; all logic on the rising edge
iRst  input  1  reset, synchronous, active-high
iEn  input  1  global enable; when low all state holds and oValid=0
iData_in  input  DATA_W  shared key/message input lane
iLoad_key  input  1  key beat strobe
iLoad_msg  input  1  message beat strobe
oData_out  output  DATA_W  ciphertext lane
oValid  output  1  oData_out valid this cycle
oStart  output  1  marks the first ciphertext beat of a message
oEnd  output  1  marks the last ciphertext beat of a message
oKey_ready  output  1  a complete key is held
oBusy  output  1  a message is in progress

Behaviour:
- Constants: KEY_BEATS=KEY_SIZE/DATA_W, MSG_BEATS=MSG_SIZE/DATA_W. Counters are sized $clog2(N)+1.
- Reset (iRst=1 at a clock edge): state=IDLE; key register, counters and all outputs = 0.
- FSM states: IDLE, LOAD_KEY, READY, STREAM.
- IDLE, iLoad_key & iEn:
  - iData_in shifts into the key register LSB; the register shifts left by DATA_W.
  - key_cnt increments; state goes to LOAD_KEY.
- LOAD_KEY:
  - Each iLoad_key & iEn beat shifts in one lane.
  - If iLoad_key is low, key_cnt holds (pause is allowed).
  - On beat KEY_BEATS: oKey_ready=1 next cycle, key_cnt=0, state goes to READY.
  - iLoad_msg is ignored in IDLE and LOAD_KEY.
- Lane order: lane index 0 = key bits [KEY_SIZE-1 -: DATA_W], i.e. the first loaded lane.
- READY or STREAM, iLoad_msg & iEn:
  - oData_out = iData_in XOR key lane[lane_idx], registered. Latency 1 cycle; oValid=1 for one cycle per beat.
  - lane_idx increments and wraps KEY_BEATS-1 to 0.
  - msg_cnt increments.
- First beat of a message: oStart=1 with that output beat; state goes to STREAM; oBusy=1.
- Beat MSG_BEATS: oEnd=1 with that output beat.
  - Next cycle: state=READY, oBusy=0, msg_cnt=0, lane_idx=0.
  - The key is restored to its loaded value if it was evolved.
  - oKey_ready stays 1, so a new message can start immediately.
- MSG_BEATS==1: oStart and oEnd assert in the same cycle.
- KEY_EVOLVE=1:
  - When lane_idx wraps during STREAM, the working key rotates left 1 bit. The new key takes effect from the next beat.
  - A shadow copy holds the loaded key for restore.
- KEY_EVOLVE=0: the working key is constant.
- Gaps in STREAM (iLoad_msg=0): counters and key hold; oValid=0.
- READY with iLoad_key & iLoad_msg in the same cycle: key load wins.
  - oKey_ready=0; the key register is cleared, then this beat shifted in.
  - State goes to LOAD_KEY; the message beat is dropped.
- STREAM: iLoad_key is ignored until the message completes.
- iEn low: everything freezes, including the output registers; oValid, oStart and oEnd forced to 0.
- iRst mid-operation: returns to IDLE and clears the key. A partial message is discarded with no oEnd.

Decomposition:
- Shared package xor_cipher_pkg holds:
  - state enum (IDLE, LOAD_KEY, READY, STREAM);
  - localparam functions for KEY_BEATS, MSG_BEATS and counter widths.
- One natural sub-module: xor_key_schedule. It holds the key shift register, the shadow copy, the rotate/restore logic and the lane_idx mux, and outputs the current key lane.
- The FSM, counters and output registers live in the top.

Test Plan:
All scenarios use DATA_W=8, KEY_SIZE=32, MSG_SIZE=64 unless noted.
- Basic: load key DE,AD,BE,EF; stream 8 beats of 00 -> out DE AD BE EF DE AD BE EF. oStart on beat 1 and oEnd on beat 8, 1 cycle after the input beat.
- Evolve: KEY_EVOLVE=1, same key, 8 beats of 00 -> out DE AD BE EF BD 5B 7D DF. A second message restarts at DE.
- Pauses: key load with iLoad_key low for 3 cycles mid-key, and iEn low for 2 cycles mid-message -> same ciphertext as Basic; oValid=0 during stalls.
- Collision: in READY, assert iLoad_key=iLoad_msg=1 with data 11 -> oKey_ready falls, no oValid. After 3 more key beats 22,33,44, msg 00 -> out 11.
- Reset mid-stream: iRst after 3 message beats -> next cycle all outputs 0, oKey_ready=0. Msg beats are ignored until a new key is loaded.
- Bit-serial: DATA_W=1, KEY_SIZE=4, MSG_SIZE=8, key 1,0,1,1, msg all 1 -> out 0,1,0,0,0,1,0,0 with oEnd on bit 8.
